// File: rtl/if_stage.sv
// Instruction-fetch stage of the pipelined RV32I core.
// Owns the PC, drives the word address into a combinational instruction
// memory, and registers the fetched word into the IF/ID pipeline register.
// Handles load-use stalls, redirect with flush, and halting on EBREAK.
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0033,
  parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_inst,
  output logic        halted
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;

  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;
  logic        fetched_ebreak;

  // Sequential PC is 32-bit modulo; redirect targets are forced word-aligned.
  assign pc_plus4       = pc_q + 32'd4;
  assign target_aligned = {redirect_target[31:2], 2'b00};
  assign fetched_ebreak = (imem_data == EBREAK_INST);

  // Next-state logic for PC, fetch state and the IF/ID register.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
    state_d         = state_q;
    pc_d            = pc_q;
    ifid_valid_d    = ifid_valid_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_inst_d     = ifid_inst_q;

    if (redirect) begin
      // Flush wins over stall and over a pending or fetched EBREAK.
      state_d         = ST_RUN;
      pc_d            = target_aligned;
      ifid_valid_d    = 1'b0;
      ifid_pc_d       = 32'd0;
      ifid_pc_plus4_d = 32'd0;
      ifid_inst_d     = NOP_INST;
    end else if (state_q == ST_HALTED) begin
      // PC frozen; while stalled the EBREAK stays visible to decode.
      if (!stall) begin
        ifid_valid_d    = 1'b0;
        ifid_pc_d       = 32'd0;
        ifid_pc_plus4_d = 32'd0;
        ifid_inst_d     = NOP_INST;
      end
    end else if (!stall) begin
      ifid_valid_d    = 1'b1;
      ifid_pc_d       = pc_q;
      ifid_pc_plus4_d = pc_plus4;
      ifid_inst_d     = imem_data;
      if (fetched_ebreak) begin
        state_d = ST_HALTED;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      state_q         <= ST_RUN;
      pc_q            <= RESET_PC;
      ifid_valid_q    <= 1'b0;
      ifid_pc_q       <= 32'd0;
      ifid_pc_plus4_q <= 32'd0;
      ifid_inst_q     <= NOP_INST;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_inst_q     <= ifid_inst_d;
    end
  end

  assign imem_addr     = pc_q[31:2];
  assign ifid_valid    = ifid_valid_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_inst     = ifid_inst_q;
  assign halted        = (state_q == ST_HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by a random
// phase, all compared against a behavioural fetch model kept in the bench.
module tb_if_stage;

  localparam logic [31:0] NOP    = 32'h0000_0033;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [29:0] imem_addr;
  logic [31:0] imem_data;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_inst;
  logic        halted;

  // 256-word instruction memory, aliased over the address space.
  logic [31:0] mem [0:255];
  assign imem_data = mem[imem_addr[7:0]];

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .ifid_valid      (ifid_valid),
    .ifid_pc         (ifid_pc),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_inst       (ifid_inst),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic        m_halt;
  logic        m_v;
  logic [31:0] m_ipc, m_ipc4, m_inst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_halt = 1'b0;
    m_v = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_inst = NOP;
  endtask

  task automatic model_bubble();
    m_v = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_inst = NOP;
  endtask

  // One clock of fetch behaviour, straight from the stage's rules.
  task automatic model_step(input logic st, input logic rd, input logic [31:0] tgt);
    logic [31:0] word;
    word = mem[m_pc[9:2]];
    if (rd) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_halt = 1'b0;
      model_bubble();
    end else if (m_halt) begin
      if (!st) model_bubble();
    end else if (!st) begin
      m_v = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_inst = word;
      if (word == EBREAK) m_halt = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".imem_addr"},  {2'b00, imem_addr}, {2'b00, m_pc[31:2]});
    check({tag, ".valid"},      {31'd0, ifid_valid}, {31'd0, m_v});
    check({tag, ".ifid_pc"},    ifid_pc, m_ipc);
    check({tag, ".pc_plus4"},   ifid_pc_plus4, m_ipc4);
    check({tag, ".inst"},       ifid_inst, m_inst);
    check({tag, ".halted"},     {31'd0, halted}, {31'd0, m_halt});
  endtask

  // Called at a negedge; drives inputs, clocks once, checks, returns at negedge.
  task automatic step(input string tag, input logic st, input logic rd, input logic [31:0] tgt);
    stall = st; redirect = rd; redirect_target = tgt;
    @(posedge clk);
    model_step(st, rd, tgt);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      if (mem[i] == EBREAK) mem[i] = NOP;
    end
    mem[0] = 32'h0020_81b3;  // add
    mem[1] = 32'h0000_2083;  // lw
    mem[2] = 32'h0040_2103;  // lw
    mem[3] = 32'h0080_2183;  // lw
    mem[4] = 32'h0020_e233;  // or
    mem[8'h5E] = EBREAK;     // byte 0x178
    model_reset();

    // Reset state while rst is held.
    @(negedge clk); @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // 1: straight-line fetch.
    step("seq0", 1'b0, 1'b0, 32'h0);
    step("seq1", 1'b0, 1'b0, 32'h0);
    check("seq1.lw_inst", ifid_inst, 32'h0000_2083);
    step("seq2", 1'b0, 1'b0, 32'h0);
    step("seq3", 1'b0, 1'b0, 32'h0);
    step("seq4", 1'b0, 1'b0, 32'h0);
    check("seq4.ifid_pc", ifid_pc, 32'd16);

    // 2: two-cycle stall at pc=8.
    step("rd0", 1'b0, 1'b1, 32'h0);
    step("f0", 1'b0, 1'b0, 32'h0);
    step("f4", 1'b0, 1'b0, 32'h0);
    step("stall1", 1'b1, 1'b0, 32'h0);
    step("stall2", 1'b1, 1'b0, 32'h0);
    check("stall.imem_addr", {2'b00, imem_addr}, 32'd2);
    check("stall.ifid_pc", ifid_pc, 32'd4);
    step("unstall", 1'b0, 1'b0, 32'h0);
    check("unstall.ifid_pc", ifid_pc, 32'd8);
    step("f12", 1'b0, 1'b0, 32'h0);
    step("f16", 1'b0, 1'b0, 32'h0);

    // 3: redirect together with stall at pc=20.
    step("rd_stall", 1'b1, 1'b1, 32'h0000_0024);
    check("rd_stall.inst", ifid_inst, NOP);
    check("rd_stall.imem_addr", {2'b00, imem_addr}, 32'd9);
    step("after_rd", 1'b0, 1'b0, 32'h0);
    check("after_rd.ifid_pc", ifid_pc, 32'd36);

    // 4: EBREAK at 0x178 halts fetch; redirect to 0 resumes.
    step("to_178", 1'b0, 1'b1, 32'h0000_0178);
    step("ebreak", 1'b0, 1'b0, 32'h0);
    check("ebreak.inst", ifid_inst, EBREAK);
    check("ebreak.ifid_pc", ifid_pc, 32'h178);
    step("halt_st", 1'b1, 1'b0, 32'h0);
    check("halt_st.inst", ifid_inst, EBREAK);
    for (int i = 0; i < 3; i++) step("halted", 1'b0, 1'b0, 32'h0);
    check("halted.imem_addr", {2'b00, imem_addr}, 32'h5E);
    check("halted.flag", {31'd0, halted}, 32'd1);
    step("unhalt", 1'b0, 1'b1, 32'h0);
    check("unhalt.flag", {31'd0, halted}, 32'd0);
    step("resume", 1'b0, 1'b0, 32'h0);
    check("resume.ifid_pc", ifid_pc, 32'd0);

    // 5: EBREAK squashed by simultaneous redirect; misaligned target.
    step("to_178b", 1'b0, 1'b1, 32'h0000_0178);
    step("eb_rd", 1'b0, 1'b1, 32'h0000_0040);
    check("eb_rd.halted", {31'd0, halted}, 32'd0);
    step("eb_rd_next", 1'b0, 1'b0, 32'h0);
    check("eb_rd_next.ifid_pc", ifid_pc, 32'h40);
    step("misalign", 1'b0, 1'b1, 32'h0000_0043);
    check("misalign.imem_addr", {2'b00, imem_addr}, 32'h10);

    // EBREAK fetched under stall is not latched.
    step("to_178c", 1'b0, 1'b1, 32'h0000_0178);
    step("eb_stall", 1'b1, 1'b0, 32'h0);
    check("eb_stall.halted", {31'd0, halted}, 32'd0);
    step("eb_release", 1'b0, 1'b0, 32'h0);

    // 6: PC wrap and asynchronous reset.
    if (mem[255] == EBREAK) mem[255] = NOP;
    step("to_top", 1'b0, 1'b1, 32'hFFFF_FFFC);
    step("wrap", 1'b0, 1'b0, 32'h0);
    check("wrap.imem_addr", {2'b00, imem_addr}, 32'd0);
    check("wrap.pc_plus4", ifid_pc_plus4, 32'd0);
    step("pre_rst", 1'b0, 1'b0, 32'h0);
    #2 rst = 1'b1;
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h100;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;
    stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    // One rising edge with idle inputs passes between reset release and here; advance the model by it.
    model_step(1'b0, 1'b0, 32'h0);
    check_all("post_rst");

    // Random phase with a few EBREAKs sprinkled through memory.
    for (int i = 0; i < 4; i++) mem[$urandom_range(5, 255)] = EBREAK;
    for (int i = 0; i < 400; i++) begin
      logic st, rd;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      step("rand", st, rd, tgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
